instr_loader: RTL and testbench

Instruction-memory writer: loads a program image into the writable instruction store that the fetch path reads combinationally by address. Accepts a stream of 9-bit instruction words over a valid/ready handshake and writes them to consecutive addresses starting at a programmable base. Sits between the test/boot interface and the instruction memory write port; the fetch path is held off while `Busy` is high.

---
 rtl/instr_loader.sv | 144 ++++++++++++++
 tb/tb_instr_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// instr_loader: writes a stream of instruction words into consecutive addresses of the
// instruction store, starting at a programmable base address.
//
// Optional feature: define INSTR_LOADER_CHECKSUM_EN to enable a trailing checksum word.
// The checksum is the sum of the data words modulo 2^DW. A mismatch is reported on ChkErr
// together with Done.
//
// Ports:
//   Clk, Reset             clock and synchronous active-high reset
//   Start                  load request, accepted in IDLE or DONE
//   BaseAddr, Length       first address and word count, captured on an accepted Start
//   InValid, InData        input word stream
//   InReady                the loader accepts a word this cycle
//   WrEn, WrAddr, WrData   registered instruction-memory write port
//   Busy, Done, ChkErr     load status
module instr_loader #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 9
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [AW-1:0] BaseAddr,
  input  logic [AW:0]   Length,
  input  logic          InValid,
  input  logic [DW-1:0] InData,
  output logic          InReady,
  output logic          WrEn,
  output logic [AW-1:0] WrAddr,
  output logic [DW-1:0] WrData,
  output logic          Busy,
  output logic          Done,
  output logic          ChkErr
);

`ifdef INSTR_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {StIdle, StLoad, StCheck, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;
`endif

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic          xfer;

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [DW-1:0] sum_q, sum_d;
  logic          chk_err_q, chk_err_d;
  // Once every data word is loaded (or none were requested), the checksum word follows.
  localparam state_e StAfterData = StCheck;
  assign Busy   = (state_q == StLoad) || (state_q == StCheck);
  assign ChkErr = chk_err_q;
`else
  localparam state_e StAfterData = StDone;
  assign Busy   = (state_q == StLoad);
  assign ChkErr = 1'b0;
`endif

  assign InReady = Busy;
  assign Done    = (state_q == StDone);
  assign WrEn    = wr_en_q;
  assign WrAddr  = wr_addr_q;
  assign WrData  = wr_data_q;
  assign xfer    = InValid && InReady;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    chk_err_d = chk_err_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        if (Start) begin
          addr_d  = BaseAddr;
          cnt_d   = Length;
`ifdef INSTR_LOADER_CHECKSUM_EN
          sum_d     = '0;
          chk_err_d = 1'b0;
`endif
          state_d = (Length == '0) ? StAfterData : StLoad;
        end
      end
      StLoad: begin
        if (xfer) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = InData;
          addr_d    = addr_q + AW'(1);  // wraps modulo 2^AW
          cnt_d     = cnt_q - (AW+1)'(1);
`ifdef INSTR_LOADER_CHECKSUM_EN
          sum_d     = sum_q + InData;
`endif
          if (cnt_q == (AW+1)'(1)) state_d = StAfterData;
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      StCheck: begin
        if (xfer) begin
          chk_err_d = (InData != sum_q);
          state_d   = StDone;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum_q     <= '0;
      chk_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
      chk_err_q <= chk_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: stimulus pushes the expected writes into a queue,
// and a monitor pops and compares them whenever WrEn is seen.
module tb_instr_loader;
  localparam int AW = 12;
  localparam int DW = 9;

  logic          Clk = 1'b0;
  logic          Reset, Start, InValid;
  logic [AW-1:0] BaseAddr;
  logic [AW:0]   Length;
  logic [DW-1:0] InData;
  logic          InReady, WrEn, Busy, Done, ChkErr;
  logic [AW-1:0] WrAddr;
  logic [DW-1:0] WrData;

  int vectors = 0;
  int miscompares = 0;
  logic [AW+DW-1:0] exp_q[$];   // {addr, data} of each expected write
  logic [DW-1:0]    preset_q[$];

  instr_loader #(.AW(AW), .DW(DW)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .BaseAddr(BaseAddr), .Length(Length),
    .InValid(InValid), .InData(InData), .InReady(InReady), .WrEn(WrEn), .WrAddr(WrAddr),
    .WrData(WrData), .Busy(Busy), .Done(Done), .ChkErr(ChkErr)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (WrEn === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", WrAddr, WrData);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        if ({WrAddr, WrData} !== e) begin
          miscompares++;
          $display("FAIL write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                   WrAddr, WrData, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain_check();
    @(negedge Clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    tick();
  endtask

  // One complete load; gap = idle cycles before each word, poke = stray Start during load.
  task automatic do_load(input int base, input int len, input int gap, input bit bad_chk,
                         input bit poke);
    logic [AW-1:0] addr;
    int            sum;
    logic [DW-1:0] w;
    addr = AW'(base);
    sum  = 0;
    Start = 1'b1; BaseAddr = AW'(base); Length = (AW+1)'(len);
    tick();
    Start = 1'b0;
`ifndef INSTR_LOADER_CHECKSUM_EN
    if (len == 0) begin
      check("len0_done", Done, 1);
      check("len0_busy", Busy, 0);
      InValid = 1'b1; InData = DW'($urandom);
      repeat (3) begin
        check("len0_inready", InReady, 0);
        tick();
      end
      InValid = 1'b0;
      check("len0_done_held", Done, 1);
      drain_check();
      return;
    end
`endif
    check("start_busy", Busy, 1);
    check("start_inready", InReady, 1);
    check("start_done_clr", Done, 0);
    for (int i = 0; i < len; i++) begin
      repeat (gap) begin
        InValid = 1'b0;
        if (poke) begin Start = 1'b1; BaseAddr = AW'($urandom); Length = (AW+1)'(1); end
        tick();
        Start = 1'b0;
      end
      w = (preset_q.size() != 0) ? preset_q.pop_front() : DW'($urandom);
      InValid = 1'b1; InData = w;
      if (poke) begin Start = 1'b1; BaseAddr = AW'($urandom); Length = (AW+1)'(1); end
      check("load_inready", InReady, 1);
      exp_q.push_back({addr, w});
      sum  = (sum + int'(w)) % (1 << DW);
      addr = addr + 1'b1;
      tick();
      InValid = 1'b0; Start = 1'b0;
      check("wr_latency", WrEn, 1);
    end
`ifdef INSTR_LOADER_CHECKSUM_EN
    check("check_busy", Busy, 1);
    check("check_done", Done, 0);
    InValid = 1'b1;
    InData  = bad_chk ? DW'(sum ^ 1) : DW'(sum);
    tick();
    InValid = 1'b0;
    check("chk_nowrite", WrEn, 0);
    check("chk_err", ChkErr, bad_chk);
`endif
    check("end_done", Done, 1);
    check("end_busy", Busy, 0);
    check("end_inready", InReady, 0);
    // Words offered after completion must be ignored.
    InValid = 1'b1; InData = DW'($urandom);
    repeat (2) tick();
    InValid = 1'b0;
    check("done_held", Done, 1);
    check("done_inready", InReady, 0);
    drain_check();
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; InValid = 1'b0; InData = '0; BaseAddr = '0; Length = '0;
    tick();
    tick();
    check("rst_inready", InReady, 0);
    check("rst_wren", WrEn, 0);
    check("rst_wraddr", WrAddr, 0);
    check("rst_wrdata", WrData, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_chkerr", ChkErr, 0);
    Reset = 1'b0;
    tick();

    // Back-to-back load of three fixed words.
    preset_q = '{9'h1A5, 9'h0FF, 9'h100};
    do_load(12'h010, 3, 0, 1'b0, 1'b0);
    // Throttled: one word every third cycle.
    do_load(12'h200, 4, 2, 1'b0, 1'b0);
    // Address wrap.
    do_load(12'hFFE, 4, 0, 1'b0, 1'b0);
    // Zero length.
    do_load(12'h345, 0, 0, 1'b0, 1'b0);

    // Reset after two of five words.
    Start = 1'b1; BaseAddr = 12'h100; Length = 13'd5;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      logic [DW-1:0] w;
      w = DW'($urandom);
      InValid = 1'b1; InData = w;
      exp_q.push_back({AW'(12'h100 + i), w});
      tick();
    end
    Reset = 1'b1; InData = DW'($urandom);
    tick();
    Reset = 1'b0; InValid = 1'b0;
    check("mid_rst_wren", WrEn, 0);
    check("mid_rst_wraddr", WrAddr, 0);
    check("mid_rst_wrdata", WrData, 0);
    check("mid_rst_busy", Busy, 0);
    check("mid_rst_done", Done, 0);
    check("mid_rst_inready", InReady, 0);
    InValid = 1'b1;
    repeat (3) tick();
    InValid = 1'b0;
    drain_check();
    do_load(12'h0A0, 5, 0, 1'b0, 1'b0);

`ifdef INSTR_LOADER_CHECKSUM_EN
    preset_q = '{9'h1FF, 9'h002};
    do_load(12'h300, 2, 0, 1'b0, 1'b0);
    preset_q = '{9'h1FF, 9'h002};
    do_load(12'h300, 2, 0, 1'b1, 1'b0);
`endif

    // Randomised loads with stray Start pulses during the load.
    for (int n = 0; n < 8; n++) begin
      do_load(int'($urandom_range(0, (1 << AW) - 1)), int'($urandom_range(1, 8)),
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
